// File: rtl/writedata_capture_pkg.sv
// Shared definitions for the write-data capture path: FSM encoding and default sizing.
package writedata_capture_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int DEF_WORD_BITS  = 16;
  localparam int DEF_DEPTH_LOG2 = 4;
  localparam int DEF_TIMEOUT    = 4095;
  localparam int TMO_W          = 12;
  localparam int BCNT_W         = 5;

endpackage

// File: rtl/writedata_fifo.sv
// Word FIFO with extra-MSB pointers; a push at full succeeds only when a pop frees a slot in the same cycle.
module writedata_fifo #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  empty,
  output logic                  full,
  output logic                  drop,
  output logic [DEPTH_LOG2-1:0] wr_addr,
  output logic [DEPTH_LOG2-1:0] rd_addr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;
  logic [WIDTH-1:0]    mem [DEPTH];
  logic                pop_ok, push_ok;

  assign wr_addr = wr_ptr[DEPTH_LOG2-1:0];
  assign rd_addr = rd_ptr[DEPTH_LOG2-1:0];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_addr == rd_addr);

  // A pop on an empty FIFO is silently ignored, even alongside a push.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign drop    = push & full & ~pop_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // At full with a pop, the write slot is the head being popped; the read is
  // combinational, so the old head is consumed before it is overwritten.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_addr] <= push_data;
  end

  assign rd_data = empty ? '0 : mem[rd_addr];

endmodule

// File: rtl/writedata_capture.sv
// Synchronizes the tag's serial write-data stream, frames it into words and queues them for readout.
module writedata_capture
  import writedata_capture_pkg::*;
#(
  parameter int WORD_BITS  = DEF_WORD_BITS,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  writedataout,
  input  logic                  writedataclk,
  input  logic                  rd_next,
  input  logic                  clear_flags,
  output logic [WORD_BITS-1:0]  rd_data,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  frame_error,
  output logic [DEPTH_LOG2-1:0] wr_addr,
  output logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [BCNT_W-1:0]     bit_count
);

  logic clk_s1, clk_s2, clk_s3;
  logic data_s1, data_s2;
  logic rd_next_q;
  logic strobe, pop, drop;

  state_e               state, state_nxt;
  logic [WORD_BITS-2:0] shreg, shreg_nxt;
  logic [BCNT_W-1:0]    bcnt, bcnt_nxt;
  logic [TMO_W-1:0]     tcnt, tcnt_nxt;
  logic                 push, tmo;
  logic [WORD_BITS-1:0] push_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1    <= 1'b0;
      clk_s2    <= 1'b0;
      clk_s3    <= 1'b0;
      data_s1   <= 1'b0;
      data_s2   <= 1'b0;
      rd_next_q <= 1'b0;
    end else begin
      clk_s1    <= writedataclk;
      clk_s2    <= clk_s1;
      clk_s3    <= clk_s2;
      data_s1   <= writedataout;
      data_s2   <= data_s1;
      rd_next_q <= rd_next;
    end
  end

  assign strobe    = clk_s2 & ~clk_s3;
  assign pop       = rd_next & ~rd_next_q;
  assign push_data = {shreg, data_s2};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      bcnt  <= '0;
      tcnt  <= '0;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      bcnt  <= bcnt_nxt;
      tcnt  <= tcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    bcnt_nxt  = bcnt;
    tcnt_nxt  = tcnt;
    push      = 1'b0;
    tmo       = 1'b0;
    case (state)
      IDLE: begin
        bcnt_nxt = '0;
        tcnt_nxt = '0;
        if (strobe) begin
          shreg_nxt = push_data[WORD_BITS-2:0];
          bcnt_nxt  = BCNT_W'(1);
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (strobe) begin
          shreg_nxt = push_data[WORD_BITS-2:0];
          tcnt_nxt  = '0;
          if (bcnt == BCNT_W'(WORD_BITS - 1)) begin
            push      = 1'b1;
            bcnt_nxt  = '0;
            state_nxt = IDLE;
          end else begin
            bcnt_nxt = bcnt + 1'b1;
          end
        end else if (tcnt == TMO_W'(TIMEOUT)) begin
          // Tag stalled mid-word: abandon the partial bits.
          tmo       = 1'b1;
          shreg_nxt = '0;
          bcnt_nxt  = '0;
          tcnt_nxt  = '0;
          state_nxt = IDLE;
        end else begin
          tcnt_nxt = tcnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Clear wins over a same-cycle set.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow    <= 1'b0;
      frame_error <= 1'b0;
    end else if (clear_flags) begin
      overflow    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      if (drop) overflow    <= 1'b1;
      if (tmo)  frame_error <= 1'b1;
    end
  end

  assign bit_count = bcnt;

  writedata_fifo #(
    .WIDTH      (WORD_BITS),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .drop      (drop),
    .wr_addr   (wr_addr),
    .rd_addr   (rd_addr)
  );

endmodule

// File: tb/tb_writedata_capture.sv
// Scoreboard bench for writedata_capture: a queue model of the FIFO fed by stimulus, drained by a pop monitor.
module tb_writedata_capture;

  localparam int W     = 16;
  localparam int DL    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset, writedataout, writedataclk, rd_next, clear_flags;
  logic [W-1:0]  rd_data;
  logic          empty, full, overflow, frame_error;
  logic [DL-1:0] wr_addr, rd_addr;
  logic [4:0]    bit_count;

  writedata_capture #(.WORD_BITS(W), .DEPTH_LOG2(DL), .TIMEOUT(4095)) dut (
    .clk(clk), .reset(reset), .writedataout(writedataout), .writedataclk(writedataclk),
    .rd_next(rd_next), .clear_flags(clear_flags), .rd_data(rd_data), .empty(empty),
    .full(full), .overflow(overflow), .frame_error(frame_error), .wr_addr(wr_addr),
    .rd_addr(rd_addr), .bit_count(bit_count)
  );

  always #5 clk = ~clk;

  int          checks = 0, errors = 0;
  logic [W-1:0] exp_q[$];
  int          n_push = 0, n_pop = 0;
  bit          exp_ovf = 0, exp_ferr = 0;
  bit          rd_prev = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: each rising rd_next is a pop request; the head must match the model.
  always @(negedge clk) begin
    if (rd_next && !rd_prev) begin
      if (exp_q.size() > 0) begin
        chk("pop_data", rd_data, exp_q.pop_front());
        n_pop++;
      end else begin
        chk("pop_while_empty", empty, 1);
      end
    end
    rd_prev = rd_next;
  end

  task automatic check_status(input string tag);
    chk({tag, "_empty"}, empty, exp_q.size() == 0);
    chk({tag, "_full"},  full,  exp_q.size() == DEPTH);
    chk({tag, "_ovf"},   overflow, exp_ovf);
    chk({tag, "_ferr"},  frame_error, exp_ferr);
    chk({tag, "_wr"},    wr_addr, n_push % DEPTH);
    chk({tag, "_rd"},    rd_addr, n_pop % DEPTH);
    chk({tag, "_bits"},  bit_count, 0);
    chk({tag, "_data"},  rd_data, (exp_q.size() == 0) ? 0 : exp_q[0]);
  endtask

  // One bit, strobe spacing 9 cycles; the rise reaches the FSM on the 3rd edge.
  task automatic send_bit(input bit b, input bit last, input bit pulse);
    writedataout = b;
    cyc(2);
    writedataclk = 1'b1;
    cyc(2);
    if (last) begin
      chk("lat_bits_before", bit_count, W - 1);
      chk("lat_empty_before", empty, exp_q.size() == 0);
    end
    if (pulse) rd_next = 1'b1;
    cyc(1);
    if (pulse) rd_next = 1'b0;
    if (last) begin
      chk("lat_bits_after", bit_count, 0);
      chk("lat_empty_after", empty, 0);
    end
    cyc(1);
    writedataclk = 1'b0;
    cyc(3);
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit pulse);
    for (int i = W - 1; i >= 0; i--) send_bit(w[i], i == 0, pulse && i == 0);
    if (exp_q.size() < DEPTH) begin
      exp_q.push_back(w);
      n_push++;
    end else begin
      exp_ovf = 1;
    end
  endtask

  task automatic pop_word();
    rd_next = 1'b1;
    cyc(1);
    rd_next = 1'b0;
    cyc(1);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    cyc(1);
    exp_q.delete();
    n_push = 0; n_pop = 0; exp_ovf = 0; exp_ferr = 0;
    check_status(tag);
    reset = 1'b0;
    cyc(1);
  endtask

  task automatic do_clear();
    clear_flags = 1'b1;
    cyc(1);
    clear_flags = 1'b0;
    exp_ovf = 0; exp_ferr = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; writedataout = 0; writedataclk = 0; rd_next = 0; clear_flags = 0;
    cyc(3);
    do_reset("reset");

    // Single word
    send_word(16'hA5C3, 0);
    check_status("single");
    chk("single_word", rd_data, 16'hA5C3);
    pop_word();
    check_status("single_pop");

    // Partial word, then timeout
    for (int i = 0; i < 7; i++) send_bit($urandom_range(0, 1), 0, 0);
    cyc(3990);
    chk("tmo_not_yet_ferr", frame_error, 0);
    chk("tmo_not_yet_bits", bit_count, 7);
    cyc(200);
    exp_ferr = 1;
    check_status("tmo");
    send_word(16'h1234, 0);
    check_status("tmo_next");
    pop_word();
    do_clear();
    check_status("clear");

    // Overflow: 17 words, no pops
    for (int i = 0; i < 17; i++) send_word(16'(i), 0);
    check_status("ovf");
    for (int i = 0; i < 16; i++) pop_word();
    check_status("ovf_drain");
    do_clear();

    // Wrap-around from a clean start
    do_reset("reset2");
    for (int i = 0; i < 10; i++) send_word(16'($urandom), 0);
    for (int i = 0; i < 10; i++) pop_word();
    for (int i = 0; i < 10; i++) begin
      send_word(16'($urandom), 0);
      check_status("wrap_fill");
    end
    chk("wrap_wr_addr", wr_addr, 4);
    chk("wrap_rd_addr", rd_addr, 10);
    for (int i = 0; i < 10; i++) pop_word();
    check_status("wrap_drain");

    // Simultaneous push and pop at full
    do_reset("reset3");
    for (int i = 0; i < 16; i++) send_word(16'($urandom), 0);
    check_status("sim_full");
    send_word(16'hC0DE, 1);
    check_status("sim_after");
    for (int i = 0; i < 16; i++) pop_word();
    check_status("sim_drain");

    // Reset mid-word with words buffered
    do_reset("reset4");
    for (int i = 0; i < 3; i++) send_word(16'($urandom), 0);
    for (int i = 0; i < 9; i++) send_bit($urandom_range(0, 1), 0, 0);
    do_reset("reset_mid");
    send_word(16'hBEEF, 0);
    check_status("beef");
    pop_word();
    check_status("beef_pop");

    // Random interleaving, including pops while empty
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 1) == 1) send_word(16'($urandom), 0);
      else pop_word();
      check_status("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
